// File: rtl/downsampler_4x.sv
// downsampler_4x: 4x4 box-average downsampler for a raster pixel stream, one pixel per cycle.
// Ports: clock, reset (sync, active-low), valid/data (input pixel), current_colcount/current_rowcount
// (position of next accepted pixel), dataout/validout (averaged pixel + one-cycle qualifier),
// frame_done (pulses with the last output of a frame).
module downsampler_4x #(
  parameter int NUMCOL = 800,
  parameter int NUMROW = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic [9:0] current_colcount,
  output logic [9:0] current_rowcount,
  output logic [7:0] dataout,
  output logic       validout,
  output logic       frame_done
);
  localparam int NB = NUMCOL / 4;
  localparam int AW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [9:0] COL_MAX = 10'(NUMCOL - 1);
  localparam logic [9:0] ROW_MAX = 10'(NUMROW - 1);
  logic [9:0] col_q, col_d, row_q, row_d, hacc_q, hacc_d;
  logic [7:0] dout_q, dout_d;
  logic vout_q, vout_d, fdone_q, fdone_d;
  logic [11:0] lbuf [NB];
  logic [11:0] entry, hsum, total, lb_wd;
  logic [AW-1:0] idx;
  logic col_last, row_last, c3, blk, lb_we;
  always_comb begin
    idx = AW'(col_q >> 2);
    entry = lbuf[idx];
    hsum = 12'(hacc_q) + 12'(data);
    total = entry + hsum;
    col_last = col_q == COL_MAX;
    row_last = row_q == ROW_MAX;
    c3 = valid && col_q[1:0] == 2'd3;
    blk = c3 && row_q[1:0] == 2'd3;
    col_d = valid ? (col_last ? '0 : col_q + 10'd1) : col_q;
    row_d = valid && col_last ? (row_last ? '0 : row_q + 10'd1) : row_q;
    hacc_d = valid ? (col_q[1:0] == 2'd0 ? 10'(data) : hacc_q + 10'(data)) : hacc_q;
    // Row 0 of each block band overwrites, so stale contents from a previous frame never leak in.
    lb_we = c3 && row_q[1:0] != 2'd3;
    lb_wd = row_q[1:0] == 2'd0 ? hsum : total;
    vout_d = blk;
    dout_d = blk ? total[11:4] : dout_q;
    fdone_d = blk && col_last && row_last;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      hacc_q <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      hacc_q <= hacc_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      fdone_q <= fdone_d;
    end
  end
  always_ff @(posedge clock) begin
    if (reset && lb_we) lbuf[idx] <= lb_wd;
  end
  assign current_colcount = col_q;
  assign current_rowcount = row_q;
  assign dataout = dout_q;
  assign validout = vout_q;
  assign frame_done = fdone_q;
endmodule

// File: tb/tb_downsampler_4x.sv
// tb_downsampler_4x: directed self-checking bench for downsampler_4x on a reduced 16x8 frame.
module tb_downsampler_4x;
  localparam int NC = 16;
  localparam int NR = 8;
  localparam int NB = (NC / 4) * (NR / 4);
  logic clock = 1'b0, reset = 1'b0, valid = 1'b0;
  logic [7:0] data = '0;
  logic [9:0] current_colcount, current_rowcount;
  logic [7:0] dataout;
  logic validout, frame_done;
  int n_cmp = 0, n_bad = 0;
  int outs[$];
  int fd_cnt = 0, fd_pos = 0;
  downsampler_4x #(.NUMCOL(NC), .NUMROW(NR)) dut (
    .clock(clock), .reset(reset), .valid(valid), .data(data),
    .current_colcount(current_colcount), .current_rowcount(current_rowcount),
    .dataout(dataout), .validout(validout), .frame_done(frame_done)
  );
  always #5 clock = ~clock;
  function automatic logic [7:0] pix(input int m, input int r, input int c);
    case (m)
      0: return 8'd100;
      1: return 8'((r % 4) * 4 + (c % 4));
      2: return 8'd255;
      3: return (r < 4 && c < 4) ? 8'd16 : 8'd0;
      5: return 8'd50;
      default: return 8'd0;
    endcase
  endfunction
  task automatic step(input logic v, input logic [7:0] d);
    valid = v;
    data = d;
    @(posedge clock);
    #1;
    if (validout) outs.push_back(int'(dataout));
    if (frame_done) begin
      fd_cnt++;
      fd_pos = outs.size();
    end
  endtask
  task automatic clear_log;
    outs.delete();
    fd_cnt = 0;
    fd_pos = 0;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    reset = 1'b1;
    clear_log();
  endtask
  task automatic feed_frame(input int m);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) step(1'b1, pix(m, r, c));
  endtask
  function automatic int count_not(input int v);
    int n = 0;
    foreach (outs[i]) if (outs[i] != v) n++;
    return n;
  endfunction
  task automatic test_reset;
    reset = 1'b0;
    step(1'b1, 8'd77);
    step(1'b1, 8'd77);
    n_cmp += 5;
    if (current_colcount !== 10'd0) begin n_bad++; $display("FAIL reset_col got %0d want 0", current_colcount); end
    if (current_rowcount !== 10'd0) begin n_bad++; $display("FAIL reset_row got %0d want 0", current_rowcount); end
    if (dataout !== 8'd0) begin n_bad++; $display("FAIL reset_dataout got %0d want 0", dataout); end
    if (validout !== 1'b0) begin n_bad++; $display("FAIL reset_validout got %0b want 0", validout); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    reset = 1'b1;
    valid = 1'b0;
  endtask
  task automatic test_constant;
    do_reset();
    feed_frame(0);
    step(1'b0, 8'd0);
    n_cmp += 4;
    if (outs.size() != NB) begin n_bad++; $display("FAIL const_count got %0d want %0d", outs.size(), NB); end
    if (count_not(100) != 0) begin n_bad++; $display("FAIL const_values got %0d wrong want 0", count_not(100)); end
    if (fd_cnt != 1) begin n_bad++; $display("FAIL const_frame_done_count got %0d want 1", fd_cnt); end
    if (fd_pos != NB) begin n_bad++; $display("FAIL const_frame_done_pos got %0d want %0d", fd_pos, NB); end
  endtask
  task automatic test_back_to_back;
    do_reset();
    feed_frame(1);
    n_cmp += 2;
    if (outs.size() != NB) begin n_bad++; $display("FAIL pattern_count got %0d want %0d", outs.size(), NB); end
    if (count_not(7) != 0) begin n_bad++; $display("FAIL pattern_values got %0d wrong want 0", count_not(7)); end
    clear_log();
    feed_frame(2);
    n_cmp += 3;
    if (outs.size() != NB) begin n_bad++; $display("FAIL max_count got %0d want %0d", outs.size(), NB); end
    if (count_not(255) != 0) begin n_bad++; $display("FAIL max_values got %0d wrong want 0", count_not(255)); end
    if (fd_cnt != 1) begin n_bad++; $display("FAIL max_frame_done got %0d want 1", fd_cnt); end
  endtask
  task automatic test_gaps;
    int nfrz = 0;
    logic [9:0] sc, sr;
    logic [7:0] sd;
    do_reset();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        while ($urandom_range(1, 0) == 1 && nfrz < 1000) begin
          sc = current_colcount;
          sr = current_rowcount;
          sd = dataout;
          step(1'b0, 8'($urandom));
          if (current_colcount !== sc || current_rowcount !== sr || dataout !== sd || validout !== 1'b0) nfrz++;
        end
        step(1'b1, pix(1, r, c));
      end
    n_cmp += 4;
    if (nfrz != 0) begin n_bad++; $display("FAIL gaps_frozen got %0d changes want 0", nfrz); end
    if (outs.size() != NB) begin n_bad++; $display("FAIL gaps_count got %0d want %0d", outs.size(), NB); end
    if (count_not(7) != 0) begin n_bad++; $display("FAIL gaps_values got %0d wrong want 0", count_not(7)); end
    if (fd_cnt != 1) begin n_bad++; $display("FAIL gaps_frame_done got %0d want 1", fd_cnt); end
  endtask
  task automatic test_stale;
    int first;
    do_reset();
    feed_frame(3);
    first = outs.size() > 0 ? outs[0] : -1;
    n_cmp += 3;
    if (first != 16) begin n_bad++; $display("FAIL stale_first got %0d want 16", first); end
    void'(outs.pop_front());
    if (count_not(0) != 0) begin n_bad++; $display("FAIL stale_rest got %0d nonzero want 0", count_not(0)); end
    if (outs.size() != NB - 1) begin n_bad++; $display("FAIL stale_count got %0d want %0d", outs.size(), NB - 1); end
    clear_log();
    feed_frame(4);
    n_cmp += 2;
    if (outs.size() != NB) begin n_bad++; $display("FAIL zero_count got %0d want %0d", outs.size(), NB); end
    if (count_not(0) != 0) begin n_bad++; $display("FAIL zero_values got %0d nonzero want 0", count_not(0)); end
  endtask
  task automatic test_reset_mid;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NC; c++)
        if (r < 2 || c < 10) step(1'b1, 8'd200);
    reset = 1'b0;
    step(1'b1, 8'd50);
    reset = 1'b1;
    valid = 1'b0;
    clear_log();
    n_cmp += 2;
    if (current_colcount !== 10'd0) begin n_bad++; $display("FAIL mid_col got %0d want 0", current_colcount); end
    if (current_rowcount !== 10'd0) begin n_bad++; $display("FAIL mid_row got %0d want 0", current_rowcount); end
    feed_frame(5);
    n_cmp += 2;
    if (outs.size() != NB) begin n_bad++; $display("FAIL mid_count got %0d want %0d", outs.size(), NB); end
    if (count_not(50) != 0) begin n_bad++; $display("FAIL mid_values got %0d wrong want 0", count_not(50)); end
  endtask
  task automatic test_timing;
    int bad_t = 0;
    logic exp_v;
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NC; c++) begin
        step(1'b1, pix(1, r, c));
        exp_v = (r == 3 && c % 4 == 3);
        if (validout !== exp_v) bad_t++;
        if (r == 3 && c >= 3 && dataout !== 8'd7) bad_t++;
      end
    n_cmp++;
    if (bad_t != 0) begin n_bad++; $display("FAIL timing_pulses got %0d errors want 0", bad_t); end
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NC; c++)
        if (r < 3 || c < 3) step(1'b1, pix(1, r, c));
    reset = 1'b0;
    step(1'b1, pix(1, 3, 3));
    reset = 1'b1;
    valid = 1'b0;
    n_cmp += 2;
    if (validout !== 1'b0) begin n_bad++; $display("FAIL suppress_validout got %0b want 0", validout); end
    if (dataout !== 8'd0) begin n_bad++; $display("FAIL suppress_dataout got %0d want 0", dataout); end
  endtask
  initial begin
    test_reset();
    test_constant();
    test_back_to_back();
    test_gaps();
    test_stale();
    test_reset_mid();
    test_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/downsampler_4x.md
DOWNSAMPLER_4X -- requirements
Module: downsampler_4x

Interface
REQ-001 Parameter NUMCOL, default 800, input frame width in pixels; SHALL be a multiple of 4.
REQ-002 Parameter NUMROW, default 600, input frame height in lines; SHALL be a multiple of 4.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 valid  input  1  qualifies data; one input pixel SHALL be accepted per cycle in which valid=1.
REQ-006 data  input  8  input pixel, raster order (left to right, top to bottom).
REQ-007 current_colcount  output  10  column of the next pixel to be accepted.
REQ-008 current_rowcount  output  10  row of the next pixel to be accepted.
REQ-009 dataout  output  8  downsampled pixel (4x4 box average).
REQ-010 validout  output  1  one-cycle pulse qualifying dataout.
REQ-011 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Column counter SHALL increment on each accepted pixel, and SHALL wrap from NUMCOL-1 to 0 while incrementing the row counter.
REQ-013 Row counter SHALL wrap from NUMROW-1 to 0; counters SHALL hold when valid=0.
REQ-014 Horizontal accumulator (10 bit) SHALL load data on an accepted pixel with col%4==0, and SHALL add data on col%4 in 1..3.
REQ-015 Line buffer SHALL hold NUMCOL/4 entries of 12 bits, indexed by col/4.
REQ-016 On an accepted pixel with col%4==3, hsum = horizontal accumulator + data.
REQ-017 In that case, when row%4==0 the entry SHALL be overwritten with hsum; when row%4 is 1 or 2 the entry SHALL be overwritten with entry+hsum.
REQ-018 When row%4==3 and col%4==3, total = entry+hsum (12 bit, max 4080, no overflow).
REQ-019 In that case, dataout SHALL be registered as total[11:4] (truncation, no rounding).
REQ-020 validout SHALL be 1 exactly in the cycle after each such accepted pixel, and 0 otherwise.
REQ-021 dataout SHALL hold its last value when validout=0.
REQ-022 Output SHALL be NUMCOL/4 pulses per 4 input rows, and (NUMCOL/4)*(NUMROW/4) pulses per frame (30000 at defaults).
REQ-023 Latency SHALL be 1 cycle from acceptance of a block's final pixel (row%4==3, col%4==3) to validout.
REQ-024 frame_done SHALL pulse in the same cycle as the validout for block (NUMROW/4-1, NUMCOL/4-1).
REQ-025 Back-to-back frames SHALL need no idle cycles; row-0 overwrite (REQ-017) SHALL make stale line-buffer contents irrelevant.
REQ-026 Idle gaps (valid=0) of any length at any position SHALL NOT change output values or count.
REQ-027 Line-buffer read-modify-write SHALL sustain one accepted pixel per cycle with no stall and no input backpressure.

Reset
REQ-028 While reset=0: colcount=0, rowcount=0, horizontal accumulator=0, dataout=0, validout=0, frame_done=0.
REQ-029 Line-buffer contents need not be cleared by reset.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after reset is (row 0, col 0).
REQ-031 Reset in the cycle after a block's final pixel SHALL suppress that validout.

Verification
REQ-032 Constant frame, data=100, valid=1 continuously -> 30000 validout pulses, all dataout=100, one frame_done, coinciding with pulse 30000.
REQ-033 data=(row%4)*4+(col%4) -> every dataout=7 (sum 120>>4); data=255 everywhere -> every dataout=255 (total 4080, no wrap).
REQ-034 Same frame as REQ-032/033 with valid deasserted pseudo-randomly ~50% of cycles -> identical dataout sequence, counters frozen on valid=0 cycles.
REQ-035 Frame with only block (0,0) = 16 and all else 0 -> first output 16, remaining 29999 outputs 0; second frame all 0 -> all 0 (no stale data).
REQ-036 Reset asserted at row 2, col 100, then full frame of 50 -> counters read 0/0 after reset, exactly 30000 outputs of 50.
REQ-037 validout timing: final pixel of block (3,3)-(0,0) accepted at cycle N -> validout=1 at N+1 only, dataout valid at N+1.
